// File: rtl/ddr_rr_arbiter_pkg.sv
// rtl/ddr_rr_arbiter_pkg.sv - state encodings and AXI tie-off constants for the DDR arbiter
package ddr_rr_arbiter_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t ST_IDLE    = 3'd0;
    localparam arb_state_t ST_WR      = 3'd1;
    localparam arb_state_t ST_WR_RESP = 3'd2;
    localparam arb_state_t ST_RD      = 3'd3;
    localparam arb_state_t ST_RD_DATA = 3'd4;
    localparam arb_state_t ST_DONE    = 3'd5;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
    localparam logic       AXI_ID_ZERO    = 1'b0;
    localparam logic       AXI_WLAST      = 1'b1;

    // AxSIZE encodes bytes per beat as log2.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/ddr_rr_arbiter_if.sv
// rtl/ddr_rr_arbiter_if.sv - requester-side and AXI-side signal bundle of the DDR arbiter
interface ddr_rr_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*ADDR_W-1:0]   req_addr;
    logic [NREQ*DATA_W-1:0]   req_wdata;
    logic [NREQ*DATA_W/8-1:0] req_wstrb;
    logic [DATA_W-1:0]        req_rdata;
    logic [NREQ-1:0]          req_ready;

    logic [ADDR_W-1:0]        m_axi_awaddr;
    logic                     m_axi_awvalid;
    logic                     m_axi_awready;
    logic [DATA_W-1:0]        m_axi_wdata;
    logic [DATA_W/8-1:0]      m_axi_wstrb;
    logic                     m_axi_wvalid;
    logic                     m_axi_wready;
    logic                     m_axi_bvalid;
    logic                     m_axi_bready;
    logic [ADDR_W-1:0]        m_axi_araddr;
    logic                     m_axi_arvalid;
    logic                     m_axi_arready;
    logic [DATA_W-1:0]        m_axi_rdata;
    logic                     m_axi_rvalid;
    logic                     m_axi_rready;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb,
        output req_rdata, req_ready,
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rvalid
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb,
        input  req_rdata, req_ready,
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rvalid
    );

endinterface

// File: rtl/ddr_rr_arbiter_rr_prio_sel.sv
// rtl/ddr_rr_arbiter_rr_prio_sel.sv - rotate-from-pointer priority select, one-hot grant plus index
module rr_prio_sel #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    // ptr is always below N, so ptr+i needs at most one subtraction to wrap.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            pos = sum[IDX_W-1:0];
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = pos;
            end
        end
    end

endmodule

// File: rtl/ddr_rr_arbiter.sv
// rtl/ddr_rr_arbiter.sv - round-robin arbiter turning single-word native requests into single-beat AXI4
module ddr_rr_arbiter
    import ddr_rr_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst,
    ddr_rr_arbiter_if.master bus
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int STRB_W = DATA_W / 8;

    arb_state_t        state;
    logic [IDX_W-1:0]  g;
    logic [IDX_W-1:0]  ptr;
    logic [NREQ-1:0]   grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic              aw_done;
    logic              w_done;

    logic [NREQ-1:0]   sel_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;

    logic aw_hs;
    logic w_hs;

    rr_prio_sel #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_prio_sel (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (sel_grant),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Only the granted requester's slice is ever looked at.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_grant[i]) begin
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = bus.req_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    assign bus.m_axi_awaddr  = addr_q;
    assign bus.m_axi_awvalid = (state == ST_WR) && !aw_done;
    assign bus.m_axi_wdata   = wdata_q;
    assign bus.m_axi_wstrb   = wstrb_q;
    assign bus.m_axi_wvalid  = (state == ST_WR) && !w_done;
    assign bus.m_axi_bready  = (state == ST_WR_RESP);
    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arvalid = (state == ST_RD);
    assign bus.m_axi_rready  = (state == ST_RD_DATA);
    assign bus.req_rdata     = rdata_q;
    assign bus.req_ready     = (state == ST_DONE) ? grant_q : '0;

    assign aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
    assign w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            g       <= '0;
            ptr     <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_found) begin
                        g       <= sel_idx;
                        grant_q <= sel_grant;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        wstrb_q <= sel_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= (sel_wstrb != '0) ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    // AW and W may finish in either order or together.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bus.m_axi_bvalid) state <= ST_DONE;
                end
                ST_RD: begin
                    if (bus.m_axi_arready) state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (bus.m_axi_rvalid) begin
                        rdata_q <= bus.m_axi_rdata;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr   <= (g == IDX_W'(NREQ - 1)) ? '0 : g + 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rr_arbiter.sv
// tb/tb_ddr_rr_arbiter.sv - directed table-driven bench for ddr_rr_arbiter with a small AXI slave model
module tb_ddr_rr_arbiter;

    logic clk;
    logic rst;

    ddr_rr_arbiter_if #(.NREQ(2), .ADDR_W(24), .DATA_W(32)) bus ();

    ddr_rr_arbiter #(.NREQ(2), .ADDR_W(24), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed;
    int total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // AXI slave model: programmable AW stall and read latency, word memory.
    int          aw_stall;
    int          rd_delay;
    int          rd_cnt;
    logic        rd_pend;
    logic [7:0]  rd_idx;
    logic        aw_got;
    logic        w_got;
    logic [23:0] aw_addr_c;
    logic [31:0] w_data_c;
    logic [3:0]  w_strb_c;
    logic [31:0] mem [0:255];

    assign bus.m_axi_awready = (aw_stall == 0);
    assign bus.m_axi_wready  = 1'b1;
    assign bus.m_axi_arready = 1'b1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        aw_stall = 0;
        rd_delay = 0;
        rd_cnt   = 0;
        rd_pend  = 1'b0;
        rd_idx   = 8'h0;
        aw_got   = 1'b0;
        w_got    = 1'b0;
        aw_addr_c = '0;
        w_data_c = '0;
        w_strb_c = '0;
        bus.m_axi_bvalid = 1'b0;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rdata  = '0;
    end

    always @(posedge clk) begin
        logic        aw_hs, w_hs;
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        aw_hs = bus.m_axi_awvalid && bus.m_axi_awready;
        w_hs  = bus.m_axi_wvalid && bus.m_axi_wready;
        a = aw_hs ? bus.m_axi_awaddr : aw_addr_c;
        d = w_hs ? bus.m_axi_wdata : w_data_c;
        s = w_hs ? bus.m_axi_wstrb : w_strb_c;
        if (aw_stall > 0 && bus.m_axi_awvalid) aw_stall <= aw_stall - 1;
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_c <= bus.m_axi_awaddr; end
        if (w_hs) begin w_got <= 1'b1; w_data_c <= bus.m_axi_wdata; w_strb_c <= bus.m_axi_wstrb; end
        if (bus.m_axi_bvalid && bus.m_axi_bready) bus.m_axi_bvalid <= 1'b0;
        if ((aw_got || aw_hs) && (w_got || w_hs) && !bus.m_axi_bvalid) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mem[a[9:2]][8*b +: 8] <= d[8*b +: 8];
            end
            bus.m_axi_bvalid <= 1'b1;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
        end
        if (bus.m_axi_rvalid && bus.m_axi_rready) bus.m_axi_rvalid <= 1'b0;
        if (bus.m_axi_arvalid && bus.m_axi_arready) begin
            if (rd_delay == 0) begin
                bus.m_axi_rvalid <= 1'b1;
                bus.m_axi_rdata  <= mem[bus.m_axi_araddr[9:2]];
            end else begin
                rd_pend <= 1'b1;
                rd_cnt  <= rd_delay - 1;
                rd_idx  <= bus.m_axi_araddr[9:2];
            end
        end
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                bus.m_axi_rvalid <= 1'b1;
                bus.m_axi_rdata  <= mem[rd_idx];
                rd_pend <= 1'b0;
            end else begin
                rd_cnt <= rd_cnt - 1;
            end
        end
    end

    typedef struct {
        logic [1:0]  mask;
        logic [23:0] addr0, addr1;
        logic [31:0] wdata0, wdata1;
        logic [3:0]  strb0, strb1;
        int          g;
        logic [31:0] exp_rdata;
        logic [31:0] exp_mem;
    } vec_t;

    localparam int NV = 8;
    vec_t vt [NV];

    task automatic drive(input logic [1:0] mask, input logic [23:0] a0, input logic [23:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic [3:0] s0, input logic [3:0] s1);
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {w1, w0};
        bus.req_wstrb = {s1, s0};
        bus.req_valid = mask;
    endtask

    int          n;
    logic        got;
    int          errs;
    int          errs_b;
    logic        saw_rvalid;
    logic [23:0] ga;
    logic [31:0] gw;
    logic [3:0]  gs;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b0;
        drive(2'b00, 24'h0, 24'h0, 32'h0, 32'h0, 4'h0, 4'h0);

        vt[0] = '{2'b01, 24'h100, 24'h000, 32'hDEADBEEF, 32'h0,  4'hF, 4'h0, 0, 32'h0,        32'hDEADBEEF};
        vt[1] = '{2'b10, 24'h000, 24'h100, 32'h0,        32'h0,  4'h0, 4'h0, 1, 32'hDEADBEEF, 32'hDEADBEEF};
        vt[2] = '{2'b11, 24'h000, 24'h004, 32'h11,       32'h22, 4'hF, 4'hF, 0, 32'hDEADBEEF, 32'h11};
        vt[3] = '{2'b11, 24'h000, 24'h004, 32'h11,       32'h22, 4'hF, 4'hF, 1, 32'hDEADBEEF, 32'h22};
        vt[4] = '{2'b11, 24'h000, 24'h004, 32'h33,       32'h44, 4'hF, 4'hF, 0, 32'hDEADBEEF, 32'h33};
        vt[5] = '{2'b01, 24'h004, 24'h000, 32'hAABBCCDD, 32'h0,  4'h3, 4'h0, 0, 32'hDEADBEEF, 32'h0000CCDD};
        vt[6] = '{2'b01, 24'h004, 24'h000, 32'h0,        32'h0,  4'h0, 4'h0, 0, 32'h0000CCDD, 32'h0000CCDD};
        vt[7] = '{2'b10, 24'h000, 24'h000, 32'h0,        32'h0,  4'h0, 4'h0, 1, 32'h33,       32'h33};

        repeat (3) @(posedge clk);
        #1;
        check("rst_awvalid",   32'(bus.m_axi_awvalid), 32'h0);
        check("rst_wvalid",    32'(bus.m_axi_wvalid),  32'h0);
        check("rst_arvalid",   32'(bus.m_axi_arvalid), 32'h0);
        check("rst_bready",    32'(bus.m_axi_bready),  32'h0);
        check("rst_rready",    32'(bus.m_axi_rready),  32'h0);
        check("rst_req_ready", 32'(bus.req_ready),     32'h0);
        check("rst_req_rdata", bus.req_rdata,          32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++) begin
            ga = (vt[k].g == 1) ? vt[k].addr1 : vt[k].addr0;
            gw = (vt[k].g == 1) ? vt[k].wdata1 : vt[k].wdata0;
            gs = (vt[k].g == 1) ? vt[k].strb1 : vt[k].strb0;
            drive(vt[k].mask, vt[k].addr0, vt[k].addr1, vt[k].wdata0, vt[k].wdata1, vt[k].strb0, vt[k].strb1);
            n = 0;
            got = 1'b0;
            while (!got && n < 40) begin
                @(posedge clk);
                #1;
                n++;
                if (n == 1) begin
                    if (gs != 4'h0) begin
                        check($sformatf("v%0d_awvalid", k), 32'(bus.m_axi_awvalid), 32'h1);
                        check($sformatf("v%0d_wvalid", k),  32'(bus.m_axi_wvalid),  32'h1);
                        check($sformatf("v%0d_awaddr", k),  32'(bus.m_axi_awaddr),  32'(ga));
                        check($sformatf("v%0d_wdata", k),   bus.m_axi_wdata,        gw);
                        check($sformatf("v%0d_wstrb", k),   32'(bus.m_axi_wstrb),   32'(gs));
                    end else begin
                        check($sformatf("v%0d_arvalid", k), 32'(bus.m_axi_arvalid), 32'h1);
                        check($sformatf("v%0d_araddr", k),  32'(bus.m_axi_araddr),  32'(ga));
                        check($sformatf("v%0d_awvalid", k), 32'(bus.m_axi_awvalid), 32'h0);
                    end
                end
                if (bus.req_ready != 2'b00) got = 1'b1;
            end
            check($sformatf("v%0d_latency", k),   32'(n),              32'd3);
            check($sformatf("v%0d_req_ready", k), 32'(bus.req_ready),  32'(1 << vt[k].g));
            check($sformatf("v%0d_req_rdata", k), bus.req_rdata,       vt[k].exp_rdata);
            bus.req_valid = 2'b00;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ready_pulse", k), 32'(bus.req_ready), 32'h0);
            check($sformatf("v%0d_mem", k), mem[ga[9:2]], vt[k].exp_mem);
        end

        // AW stalled five cycles while W completes at once.
        aw_stall = 5;
        drive(2'b01, 24'h040, 24'h0, 32'h5A5A5A5A, 32'h0, 4'hF, 4'h0);
        n = 0;
        got = 1'b0;
        errs = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.m_axi_awvalid && bus.m_axi_awaddr != 24'h040) errs++;
            if (bus.m_axi_bready && (bus.m_axi_awvalid || n < 7)) errs++;
            if (n == 2) begin
                check("stall_wvalid_drop", 32'(bus.m_axi_wvalid),  32'h0);
                check("stall_awvalid_hold", 32'(bus.m_axi_awvalid), 32'h1);
            end
            if (bus.req_ready != 2'b00) got = 1'b1;
        end
        check("stall_aw_stable_bready", 32'(errs), 32'h0);
        check("stall_latency", 32'(n), 32'd8);
        check("stall_req_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        check("stall_mem", mem[8'h10], 32'h5A5A5A5A);

        // Reset while waiting for read data; ptr is 1 going in.
        rd_delay = 3;
        drive(2'b01, 24'h040, 24'h0, 32'h0, 32'h0, 4'h0, 4'h0);
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.m_axi_rready) got = 1'b1;
        end
        check("rstrd_reach_rd_data", 32'(got), 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rstrd_awvalid",   32'(bus.m_axi_awvalid), 32'h0);
        check("rstrd_wvalid",    32'(bus.m_axi_wvalid),  32'h0);
        check("rstrd_arvalid",   32'(bus.m_axi_arvalid), 32'h0);
        check("rstrd_bready",    32'(bus.m_axi_bready),  32'h0);
        check("rstrd_rready",    32'(bus.m_axi_rready),  32'h0);
        check("rstrd_req_ready", 32'(bus.req_ready),     32'h0);
        check("rstrd_req_rdata", bus.req_rdata,          32'h0);
        rst = 1'b1;
        bus.req_valid = 2'b00;
        errs_b = 0;
        saw_rvalid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.m_axi_rvalid) saw_rvalid = 1'b1;
            if (bus.req_ready != 2'b00 || bus.m_axi_rready) errs_b++;
        end
        check("rstrd_late_rvalid_seen", 32'(saw_rvalid), 32'h1);
        check("rstrd_late_rvalid_ignored", 32'(errs_b), 32'h0);

        // Pointer must be back at 0: both requesting, requester 0 wins.
        drive(2'b11, 24'h008, 24'h00C, 32'h77, 32'h88, 4'hF, 4'hF);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.req_ready != 2'b00) got = 1'b1;
        end
        check("rstrd_ptr_latency", 32'(n), 32'd3);
        check("rstrd_ptr_grant", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        check("rstrd_ptr_mem", mem[8'h02], 32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ddr_rr_arbiter.md
Name: ddr_rr_arbiter

Overview:
- Shares the single DDR AXI4 port (axi_ram model in simulation, memory controller on FPGA) between NREQ native-interface requesters, e.g. CPU data cache and an accelerator DMA.
- Performs round-robin arbitration and converts each granted single-word native request into one single-beat AXI4 read or write.
- Allows exactly one outstanding transaction at a time.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 24, byte address width; equals DDR_ADDR_W
DATA_W, 32, data width in bits; strobe width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset (rst=0 at posedge resets)
req_valid  in  NREQ  per-requester request valid
req_addr  in  NREQ*ADDR_W  packed byte addresses; slice i belongs to requester i
req_wdata  in  NREQ*DATA_W  packed write data
req_wstrb  in  NREQ*DATA_W/8  packed strobes; all-zero means read
req_rdata  out  DATA_W  read data, shared, qualified by req_ready[i]
req_ready  out  NREQ  one-cycle completion pulse to the granted requester
m_axi_awaddr  out  ADDR_W  write address
m_axi_awvalid  out  1  write address valid
m_axi_awready  in  1  write address ready
m_axi_wdata  out  DATA_W  write data
m_axi_wstrb  out  DATA_W/8  write strobe
m_axi_wvalid  out  1  write data valid
m_axi_wready  in  1  write data ready
m_axi_bvalid  in  1  write response valid
m_axi_bready  out  1  write response ready
m_axi_araddr  out  ADDR_W  read address
m_axi_arvalid  out  1  read address valid
m_axi_arready  in  1  read address ready
m_axi_rdata  in  DATA_W  read data
m_axi_rvalid  in  1  read data valid
m_axi_rready  out  1  read data ready

Behaviour:
- Reset values: all m_axi valid and ready outputs 0; req_ready 0; req_rdata 0; state IDLE; priority pointer ptr=0.
- Reset mid-transaction abandons the transaction. Late bvalid/rvalid from the slave in IDLE are ignored; bready and rready stay 0 in IDLE. The requester must re-issue.
- Tie-offs: the instantiating top ties AxLEN=0, AxSIZE=log2(DATA_W/8), AxBURST=INCR, AxID=0, WLAST=1.
- Responses: BRESP and RRESP are not checked.
- States: IDLE, WR, WR_RESP, RD, RD_DATA, DONE.
- IDLE: if any req_valid is high, pick the first set bit scanning upward from ptr with wrap-around. Register the grant index g and requester g's addr, wdata and wstrb. Go to WR if wstrb != 0, else RD.
- WR: awvalid and wvalid both go high on entry.
  - Each drops independently the cycle after its own handshake; payloads stay stable while valid.
  - Move to WR_RESP once both handshakes are done, including when both complete in the same cycle.
- WR_RESP: bready=1. On bvalid, go to DONE.
- RD: arvalid=1 until arready; then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, register m_axi_rdata into req_rdata and go to DONE.
- DONE: req_ready[g]=1 for exactly one cycle; set ptr=(g+1) mod NREQ; go to IDLE.
  - req_rdata holds its value until the next read completes.
  - The requester must drop or update req_valid at the DONE edge. IDLE samples afresh on the following cycle.
- Requester contract: req_valid and its fields stay stable until req_ready. The block never samples non-granted slices.
- Latency, zero-wait slave, with requester sampled at edge E0: valids high after E0, address handshake at E1, response handshake at E2, req_ready high in cycle E2..E3. Total is 4 cycles per transaction including DONE.
- Fairness: a waiting requester is served after at most NREQ-1 other transactions.

Decomposition:
- Shared header ddr_arb.vh: state encodings and AXI tie-off constants (burst INCR, size from DATA_W).
- One sub-module rr_prio_sel: combinational rotate-from-ptr priority select, outputs one-hot grant and index. Reused by future arbiters.

Test Plan:
1. Write, zero-wait slave: req0 with addr 0x100, wdata 0xDEADBEEF, wstrb 0xF. Expect awaddr=0x100 and wvalid in the same cycle, req_ready[0] pulses once 3 cycles after req_valid, axi_ram word 0x100 = 0xDEADBEEF.
2. Read: req1 with addr 0x100, wstrb 0. Expect araddr=0x100 and req_rdata=0xDEADBEEF while req_ready[1] is high; req_ready[0] stays 0.
3. Simultaneous requests, ptr=0: req0 (write 0x11 to 0x0) and req1 (write 0x22 to 0x4) both valid. Expect req0 completes first, then req1, with ptr=0 afterward. If req0 requests continuously, req1 completes after at most one req0 transaction.
4. Stalls: wready accepted immediately, awready held low 5 cycles. Expect wvalid drops after its handshake, awaddr held stable, bready asserted only after the AW handshake; awready and wready in the same cycle also proceed to WR_RESP.
5. Reset mid-read: rst=0 while in RD_DATA. Expect all valids, bready, rready and req_ready are 0 the next cycle and ptr=0; an rvalid arriving 2 cycles later produces no req_ready.
